// File: rtl/pixel_plot_buffer_if.sv
// pixel_plot_buffer_if: draw-side pixel requests and VGA write-port handshake
interface pixel_plot_buffer_if;
  logic ld_xy, ld_pos, ld_colour, draw_pixel, frame_done, clr_err, vga_ready;
  logic [8:0] x, y, dx, dy, colour;
  logic [8:0] vga_x, vga_colour;
  logic [7:0] vga_y;
  logic vga_plot, fifo_full, overflow, frame_flushed;
  modport master (
    output ld_xy, ld_pos, ld_colour, draw_pixel, frame_done, clr_err, vga_ready,
    output x, y, dx, dy, colour,
    input vga_x, vga_y, vga_colour, vga_plot, fifo_full, overflow, frame_flushed
  );
  modport slave (
    input ld_xy, ld_pos, ld_colour, draw_pixel, frame_done, clr_err, vga_ready,
    input x, y, dx, dy, colour,
    output vga_x, vga_y, vga_colour, vga_plot, fifo_full, overflow, frame_flushed
  );
endinterface

// File: rtl/pixel_plot_buffer.sv
// pixel_plot_buffer: clips/keys pixels, queues them in a FIFO for the VGA port and reports frame flush
module pixel_plot_buffer #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter bit TRANSP_EN = 1'b1,
  parameter logic [8:0] TRANSP_COL = 9'h1FF,
  parameter int DEPTH_LOG2 = 4
) (
  input logic clock,
  input logic resetn,
  pixel_plot_buffer_if.slave p
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int CW = DEPTH_LOG2 + 1;
  typedef enum logic [1:0] {IDLE, WAIT, FLUSHED} state_t;
  state_t state, state_nxt;
  logic [8:0] base_x, base_y, off_x, off_y, col;
  logic [8:0] eff_dx, eff_dy, eff_col;
  logic [9:0] abs_x, abs_y;
  logic drop, full, pop, push, lost;
  logic [CW-1:0] count, count_nxt;
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [25:0] mem [DEPTH];
  logic [25:0] head;
  // offset and colour bypass their registers when loaded alongside a draw; base does not
  assign eff_dx = p.ld_pos ? p.dx : off_x;
  assign eff_dy = p.ld_pos ? p.dy : off_y;
  assign eff_col = p.ld_colour ? p.colour : col;
  assign abs_x = {1'b0, base_x} + {1'b0, eff_dx};
  assign abs_y = {1'b0, base_y} + {1'b0, eff_dy};
  assign drop = abs_x >= 10'(SCREEN_W) || abs_y >= 10'(SCREEN_H) || (TRANSP_EN && eff_col == TRANSP_COL);
  assign full = count == CW'(DEPTH);
  assign pop = p.vga_plot && p.vga_ready;
  assign push = p.draw_pixel && !drop && (!full || pop);
  assign lost = p.draw_pixel && !drop && full && !pop;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign head = mem[rd_ptr];
  assign p.vga_plot = count != '0;
  assign p.vga_x = p.vga_plot ? head[25:17] : '0;
  assign p.vga_y = p.vga_plot ? head[16:9] : '0;
  assign p.vga_colour = p.vga_plot ? head[8:0] : '0;
  assign p.fifo_full = full;
  assign p.frame_flushed = state == FLUSHED;
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= {abs_x[8:0], abs_y[7:0], eff_col};
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      base_x <= '0;
      base_y <= '0;
      off_x <= '0;
      off_y <= '0;
      col <= '0;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      p.overflow <= 1'b0;
      state <= IDLE;
    end else begin
      if (p.ld_xy) {base_x, base_y} <= {p.x, p.y};
      if (p.ld_pos) {off_x, off_y} <= {p.dx, p.dy};
      if (p.ld_colour) col <= p.colour;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      p.overflow <= lost || (p.overflow && !p.clr_err);
      state <= state_nxt;
    end
  // flush completes on the cycle the queue reaches empty, including straight from IDLE
  always_comb begin
    state_nxt = IDLE;
    state_nxt = state == IDLE ? (p.frame_done ? (count_nxt == '0 ? FLUSHED : WAIT) : IDLE) :
                state == WAIT ? (count_nxt == '0 ? FLUSHED : WAIT) : IDLE;
  end
endmodule

// File: tb/tb_pixel_plot_buffer.sv
// tb_pixel_plot_buffer: directed checks of clipping, keying, FIFO, overflow and flush behaviour
module tb_pixel_plot_buffer;
  logic clock, resetn;
  int n_chk, n_err;
  int exp_x;
  pixel_plot_buffer_if p ();
  pixel_plot_buffer_if p2 ();
  pixel_plot_buffer dut (.clock(clock), .resetn(resetn), .p(p.slave));
  pixel_plot_buffer #(.TRANSP_EN(1'b0)) dut_nokey (.clock(clock), .resetn(resetn), .p(p2.slave));
  assign p2.ld_xy = p.ld_xy;
  assign p2.ld_pos = p.ld_pos;
  assign p2.ld_colour = p.ld_colour;
  assign p2.draw_pixel = p.draw_pixel;
  assign p2.frame_done = p.frame_done;
  assign p2.clr_err = p.clr_err;
  assign p2.vga_ready = p.vga_ready;
  assign p2.x = p.x;
  assign p2.y = p.y;
  assign p2.dx = p.dx;
  assign p2.dy = p.dy;
  assign p2.colour = p.colour;
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic load_base(input int bx, input int by);
    p.ld_xy = 1'b1;
    p.x = 9'(bx);
    p.y = 9'(by);
    step();
    p.ld_xy = 1'b0;
  endtask
  task automatic draw(input int ox, input int oy, input int c);
    p.ld_pos = 1'b1;
    p.ld_colour = 1'b1;
    p.draw_pixel = 1'b1;
    p.dx = 9'(ox);
    p.dy = 9'(oy);
    p.colour = 9'(c);
    step();
    p.ld_pos = 1'b0;
    p.ld_colour = 1'b0;
    p.draw_pixel = 1'b0;
    p.ld_xy = 1'b0;
    p.clr_err = 1'b0;
  endtask
  initial begin
    n_chk = 0;
    n_err = 0;
    resetn = 1'b0;
    {p.ld_xy, p.ld_pos, p.ld_colour, p.draw_pixel, p.frame_done, p.clr_err, p.vga_ready} = '0;
    {p.x, p.y, p.dx, p.dy, p.colour} = '0;
    step();
    step();
    chk("rst_plot", p.vga_plot, 0);
    chk("rst_x", p.vga_x, 0);
    chk("rst_y", p.vga_y, 0);
    chk("rst_col", p.vga_colour, 0);
    chk("rst_full", p.fifo_full, 0);
    chk("rst_ovf", p.overflow, 0);
    chk("rst_flush", p.frame_flushed, 0);
    resetn = 1'b1;
    load_base(110, 10);
    draw(3, 4, 'h0F0);
    chk("basic_plot", p.vga_plot, 1);
    chk("basic_x", p.vga_x, 113);
    chk("basic_y", p.vga_y, 14);
    chk("basic_col", p.vga_colour, 'h0F0);
    step();
    chk("stall_x", p.vga_x, 113);
    p.vga_ready = 1'b1;
    step();
    p.vga_ready = 1'b0;
    chk("basic_drain", p.vga_plot, 0);
    p.ld_xy = 1'b1;
    p.x = 9'd50;
    p.y = 9'd60;
    draw(3, 4, 'h00F);
    draw(3, 4, 'h00F);
    chk("nobyp_x", p.vga_x, 113);
    chk("nobyp_y", p.vga_y, 14);
    p.vga_ready = 1'b1;
    step();
    chk("newbase_x", p.vga_x, 53);
    chk("newbase_y", p.vga_y, 64);
    step();
    p.vga_ready = 1'b0;
    load_base(300, 0);
    draw(25, 0, 'h00F);
    load_base(0, 235);
    draw(0, 10, 'h00F);
    chk("clip_plot", p.vga_plot, 0);
    chk("clip_ovf", p.overflow, 0);
    load_base(300, 235);
    draw(19, 4, 'h0AA);
    chk("edge_plot", p.vga_plot, 1);
    chk("edge_x", p.vga_x, 319);
    chk("edge_y", p.vga_y, 239);
    p.vga_ready = 1'b1;
    step();
    p.vga_ready = 1'b0;
    load_base(5, 5);
    draw(0, 0, 'h1FF);
    chk("key_drop", p.vga_plot, 0);
    chk("nokey_plot", p2.vga_plot, 1);
    chk("nokey_col", p2.vga_colour, 'h1FF);
    p.vga_ready = 1'b1;
    step();
    p.vga_ready = 1'b0;
    load_base(0, 0);
    for (int i = 0; i < 16; i++) draw(i, i, i + 1);
    chk("fill_full", p.fifo_full, 1);
    chk("fill_ovf", p.overflow, 0);
    draw(16, 16, 17);
    chk("ovf_set", p.overflow, 1);
    p.vga_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_x", p.vga_x, i);
      chk("drain_col", p.vga_colour, i + 1);
      step();
    end
    p.vga_ready = 1'b0;
    chk("drain_empty", p.vga_plot, 0);
    chk("ovf_sticky", p.overflow, 1);
    p.clr_err = 1'b1;
    step();
    p.clr_err = 1'b0;
    chk("ovf_clr", p.overflow, 0);
    for (int i = 0; i < 16; i++) draw(i, 0, 1);
    p.clr_err = 1'b1;
    draw(99, 0, 1);
    chk("ovf_setwins", p.overflow, 1);
    p.clr_err = 1'b1;
    step();
    p.clr_err = 1'b0;
    chk("ovf_clr2", p.overflow, 0);
    p.vga_ready = 1'b1;
    draw(40, 0, 2);
    p.vga_ready = 1'b0;
    chk("pp_full", p.fifo_full, 1);
    chk("pp_ovf", p.overflow, 0);
    chk("pp_head", p.vga_x, 1);
    p.vga_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      exp_x = j < 15 ? j + 1 : 40;
      chk("pp_drain_x", p.vga_x, exp_x);
      step();
    end
    p.vga_ready = 1'b0;
    chk("pp_empty", p.vga_plot, 0);
    for (int i = 0; i < 5; i++) draw(i, 0, 3);
    p.frame_done = 1'b1;
    step();
    p.frame_done = 1'b0;
    p.vga_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("fl_wait", p.frame_flushed, 0);
      chk("fl_plot", p.vga_plot, 1);
      p.frame_done = k == 2;
      step();
      p.frame_done = 1'b0;
    end
    p.vga_ready = 1'b0;
    chk("fl_pulse", p.frame_flushed, 1);
    chk("fl_empty", p.vga_plot, 0);
    step();
    chk("fl_single", p.frame_flushed, 0);
    step();
    chk("fl_nodup", p.frame_flushed, 0);
    p.frame_done = 1'b1;
    step();
    p.frame_done = 1'b0;
    chk("fl_immediate", p.frame_flushed, 1);
    step();
    chk("fl_imm_end", p.frame_flushed, 0);
    for (int i = 0; i < 5; i++) draw(i + 7, 0, 3);
    p.frame_done = 1'b1;
    step();
    p.frame_done = 1'b0;
    p.vga_ready = 1'b1;
    step();
    step();
    resetn = 1'b0;
    #1;
    chk("mid_rst_plot", p.vga_plot, 0);
    chk("mid_rst_x", p.vga_x, 0);
    chk("mid_rst_full", p.fifo_full, 0);
    step();
    step();
    resetn = 1'b1;
    p.vga_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("mid_rst_noflush", p.frame_flushed, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
